// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - b_in, with borrow out.
// Counterpart of the full_adder cell used in the combinational datapath.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~x & b_in) | (y & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] resShift_q;
  logic [WIDTH-1:0] diff_q;
  logic             br_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;

  logic             bitDiff;
  logic             bitBorrow;
  logic [WIDTH-1:0] resShift_d;

  full_subtractor uCell (
    .x     (aShift_q[0]),
    .y     (bShift_q[0]),
    .b_in  (br_q),
    .d     (bitDiff),
    .b_out (bitBorrow)
  );

  // New result bit enters from the MSB side so the LSB-first stream lands in order.
  assign resShift_d = (resShift_q >> 1) | {bitDiff, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      resShift_q <= '0;
      diff_q     <= '0;
      br_q       <= 1'b0;
      borrow_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aShift_q <= a;
            bShift_q <= b;
            br_q     <= borrow_in;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          aShift_q   <= aShift_q >> 1;
          bShift_q   <= bShift_q >> 1;
          br_q       <= bitBorrow;
          resShift_q <= resShift_d;
          cnt_q      <= cnt_q + CW'(1);
          // The visible result only changes once all bits are in.
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff_q   <= resShift_d;
            borrow_q <= bitBorrow;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: 8-bit vectors, backpressure, mid-run
// reset, and an exhaustive back-to-back sweep of a 4-bit instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, borrow8, busy8;
  logic [7:0] a8, b8, diff8;

  logic       in_valid4, in_ready4, bin4, out_valid4, out_ready4, borrow4, busy4;
  logic [3:0] a4, b4, diff4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid8),
    .in_ready   (in_ready8),
    .a          (a8),
    .b          (b8),
    .borrow_in  (bin8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready8),
    .diff       (diff8),
    .borrow_out (borrow8),
    .busy       (busy8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .a          (a4),
    .b          (b4),
    .borrow_in  (bin4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .diff       (diff4),
    .borrow_out (borrow4),
    .busy       (busy4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation with out_ready high; handshake edge is E0.
  task automatic applyStimulus(input string tag, input logic [7:0] aV, input logic [7:0] bV,
                               input logic binV, input logic [7:0] expD, input logic expB);
    a8 = aV; b8 = bV; bin8 = binV; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checkOutput({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    checkOutput({tag, "_inready_run"}, {31'd0, in_ready8}, 32'd0);
    repeat (7) @(posedge clk);
    #1;
    checkOutput({tag, "_outvalid_early"}, {31'd0, out_valid8}, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_outvalid"}, {31'd0, out_valid8}, 32'd1);
    checkOutput({tag, "_diff"}, {24'd0, diff8}, {24'd0, expD});
    checkOutput({tag, "_borrow"}, {31'd0, borrow8}, {31'd0, expB});
    @(posedge clk); #1;
    checkOutput({tag, "_outvalid_drop"}, {31'd0, out_valid8}, 32'd0);
    checkOutput({tag, "_inready_back"}, {31'd0, in_ready8}, 32'd1);
  endtask

  initial begin
    int     guard;
    int     lat;
    int     ai, bi, ci, r;
    longint hsTime, lastHs;

    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_inready", {31'd0, in_ready8}, 32'd1);
    checkOutput("rst_outvalid", {31'd0, out_valid8}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy8}, 32'd0);
    checkOutput("rst_diff", {24'd0, diff8}, 32'd0);
    checkOutput("rst_borrow", {31'd0, borrow8}, 32'd0);

    applyStimulus("v10m3", 8'd10, 8'd3, 1'b0, 8'h07, 1'b0);
    applyStimulus("v3m10", 8'd3, 8'd10, 1'b0, 8'hF9, 1'b1);
    applyStimulus("v0m0b", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);
    applyStimulus("vffmff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

    // Backpressure: 0x5A - 0x3C - 1 = 0x1D, result held while out_ready is low.
    out_ready8 = 1'b0;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("bp_outvalid", {31'd0, out_valid8}, 32'd1);
    checkOutput("bp_diff", {24'd0, diff8}, 32'h1D);
    a8 = 8'h01; b8 = 8'h02; bin8 = 1'b0; in_valid8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", {31'd0, out_valid8}, 32'd1);
      checkOutput("bp_hold_diff", {24'd0, diff8}, 32'h1D);
      checkOutput("bp_hold_borrow", {31'd0, borrow8}, 32'd0);
      checkOutput("bp_hold_inready", {31'd0, in_ready8}, 32'd0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", {31'd0, out_valid8}, 32'd0);
    checkOutput("bp_release_inready", {31'd0, in_ready8}, 32'd1);
    checkOutput("bp_release_busy", {31'd0, busy8}, 32'd0);
    checkOutput("bp_release_diff", {24'd0, diff8}, 32'h1D);

    // Reset sampled at the 4th edge of a running operation.
    a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mrst_inready", {31'd0, in_ready8}, 32'd1);
    checkOutput("mrst_outvalid", {31'd0, out_valid8}, 32'd0);
    checkOutput("mrst_diff", {24'd0, diff8}, 32'd0);
    checkOutput("mrst_busy", {31'd0, busy8}, 32'd0);
    applyStimulus("v100m55", 8'd100, 8'd55, 1'b0, 8'd45, 1'b0);

    // Exhaustive 4-bit sweep, producer keeps in_valid high back to back.
    lastHs = 0;
    for (int i = 0; i < 512; i++) begin
      ai = i & 15;
      bi = (i >> 4) & 15;
      ci = (i >> 8) & 1;
      r  = (ai - bi - ci) & 31;
      a4 = 4'(ai); b4 = 4'(bi); bin4 = ci[0]; in_valid4 = 1'b1;
      guard = 0;
      while (in_ready4 !== 1'b1 && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 20) checkOutput("w4_inready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      hsTime = longint'($time);
      #1;
      in_valid4 = 1'b0;
      if (i > 0) checkOutput("w4_spacing", 32'((hsTime - lastHs) / 10), 32'd6);
      lastHs = hsTime;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (out_valid4 !== 1'b1 && lat < 12);
      checkOutput("w4_latency", 32'(lat), 32'd4);
      checkOutput("w4_result", {27'd0, borrow4, diff4}, 32'(r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
